mod_n_down_counter: RTL and testbench

- Synchronous modulo-N down-counter/timer. It is the count-down counterpart of the lab's mod-5 up-counter.
- A start command loads a value. The block then decrements once per enabled cycle and pulses done on reaching zero.
- Outputs are a true/complement pair (count, count_bar), matching the flip-flop Q/Qbar style used in the counter datapath.
- Sits beside the up-counter in the Lab 4 counter path.

---
 rtl/mod_n_down_counter_if.sv | 22 ++
 rtl/mod_n_down_counter.sv | 101 ++++++++++
 tb/tb_mod_n_down_counter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_down_counter_if.sv
// Control/status bundle for mod_n_down_counter: load/run command in, count pair and status out.
interface mod_n_down_counter_if #(
    parameter int unsigned WIDTH = 3
);
    logic             enable;
    logic             start;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_bar;
    logic             busy;
    logic             done;

    modport master (
        output enable, start, load_value,
        input  count, count_bar, busy, done
    );

    modport slave (
        input  enable, start, load_value,
        output count, count_bar, busy, done
    );
endinterface

// File: rtl/mod_n_down_counter.sv
// Modulo-N down-counter/timer: start loads a clamped value, enable decrements, done pulses at zero.
// Optional MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN: start held in DONE reloads the stored value.
module mod_n_down_counter #(
    parameter int unsigned N     = 5,
    parameter int unsigned WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    mod_n_down_counter_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(N - 1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] count_bar_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] load_clamped;

`ifdef MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    assign load_clamped = (bus.load_value > MaxVal) ? MaxVal : bus.load_value;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    count_d = load_clamped;
`ifdef MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN
                    reload_d = load_clamped;
`endif
                    state_d = (load_clamped != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (bus.enable) begin
                    // Count of 0 in RUN is unreachable; treat it like 1 so we never wrap.
                    if (count_q > One) begin
                        count_d = count_q - One;
                    end else begin
                        count_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                count_d = '0;
                state_d = StIdle;
`ifdef MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN
                if (bus.start) begin
                    count_d = reload_q;
                    state_d = (reload_q != '0) ? StRun : StDone;
                end
`endif
            end
            default: begin
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Status flags and the complement are registered from next-state so they align with count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            count_bar_q <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            count_bar_q <= ~count_d;
            busy_q      <= (state_d == StRun);
            done_q      <= (state_d == StDone);
`ifdef MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q    <= reload_d;
`endif
        end
    end

    assign bus.count     = count_q;
    assign bus.count_bar = count_bar_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Directed bench for mod_n_down_counter (N=5, WIDTH=3) with hand-computed expectations.
module tb_mod_n_down_counter;

    localparam int unsigned N     = 5;
    localparam int unsigned WIDTH = 3;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mod_n_down_counter_if #(.WIDTH(WIDTH)) bus ();

    mod_n_down_counter #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Checks count, count_bar, busy and done together.
    task automatic expect_state(input string tag, input int c, input int b, input int d);
        check({tag, ".count"}, 32'(bus.count), 32'(c));
        check({tag, ".count_bar"}, 32'(bus.count_bar), 32'((~c) & 7));
        check({tag, ".busy"}, 32'(bus.busy), 32'(b));
        check({tag, ".done"}, 32'(bus.done), 32'(d));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.start = 1'b0;
        bus.load_value = '0;

        // Reset
        tick();
        tick();
        expect_state("reset", 0, 0, 0);
        reset = 1'b1;
        tick();
        expect_state("idle_after_reset", 0, 0, 0);

        // Basic count from 3
        bus.enable = 1'b1;
        bus.start = 1'b1;
        bus.load_value = 3'd3;
        tick();
        expect_state("basic_load", 3, 1, 0);
        bus.start = 1'b0;
        tick();
        expect_state("basic_2", 2, 1, 0);
        tick();
        expect_state("basic_1", 1, 1, 0);
        tick();
        expect_state("basic_done", 0, 0, 1);
        tick();
        expect_state("basic_idle", 0, 0, 0);

        // Clamp 7 -> 4
        bus.start = 1'b1;
        bus.load_value = 3'd7;
        tick();
        expect_state("clamp_load", 4, 1, 0);
        bus.start = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            tick();
            expect_state("clamp_run", i, 1, 0);
        end
        tick();
        expect_state("clamp_done", 0, 0, 1);
        tick();
        expect_state("clamp_idle", 0, 0, 0);

        // Zero load goes straight to DONE
        bus.start = 1'b1;
        bus.load_value = 3'd0;
        tick();
        expect_state("zero_done", 0, 0, 1);
        bus.start = 1'b0;
        tick();
        expect_state("zero_idle", 0, 0, 0);

        // Stalls from L=2: enable 1 (load), 0, 1, 0, 1
        bus.start = 1'b1;
        bus.load_value = 3'd2;
        bus.enable = 1'b1;
        tick();
        expect_state("stall_load", 2, 1, 0);
        bus.start = 1'b0;
        bus.enable = 1'b0;
        tick();
        expect_state("stall_hold2", 2, 1, 0);
        bus.enable = 1'b1;
        tick();
        expect_state("stall_1", 1, 1, 0);
        bus.enable = 1'b0;
        tick();
        expect_state("stall_hold1", 1, 1, 0);
        bus.enable = 1'b1;
        tick();
        expect_state("stall_done", 0, 0, 1);
        tick();
        expect_state("stall_idle", 0, 0, 0);

        // Reset mid-RUN at count 2
        bus.start = 1'b1;
        bus.load_value = 3'd4;
        tick();
        expect_state("mid_load", 4, 1, 0);
        bus.start = 1'b0;
        tick();
        tick();
        expect_state("mid_2", 2, 1, 0);
        reset = 1'b0;
        tick();
        expect_state("mid_reset", 0, 0, 0);
        reset = 1'b1;
        tick();
        expect_state("mid_no_done", 0, 0, 0);

        // start ignored in RUN
        bus.start = 1'b1;
        bus.load_value = 3'd4;
        tick();
        bus.start = 1'b0;
        tick();
        expect_state("ign_3", 3, 1, 0);
        bus.start = 1'b1;
        bus.load_value = 3'd1;
        tick();
        expect_state("ign_2", 2, 1, 0);
        bus.start = 1'b0;
        tick();
        expect_state("ign_1", 1, 1, 0);
        tick();
        expect_state("ign_done", 0, 0, 1);
        tick();
        expect_state("ign_idle", 0, 0, 0);

        // start held with load_value=2
        bus.start = 1'b1;
        bus.load_value = 3'd2;
        tick();
        expect_state("hold_load", 2, 1, 0);
        tick();
        expect_state("hold_1", 1, 1, 0);
        tick();
        expect_state("hold_done", 0, 0, 1);
`ifdef MOD_N_DOWN_COUNTER_AUTO_RELOAD_EN
        bus.load_value = 3'd3;  // must not be resampled on reload
        tick();
        expect_state("ar_reload", 2, 1, 0);
        tick();
        expect_state("ar_1", 1, 1, 0);
        tick();
        expect_state("ar_done", 0, 0, 1);
        bus.start = 1'b0;
        tick();
        expect_state("ar_idle", 0, 0, 0);
`else
        bus.load_value = 3'd3;
        tick();
        expect_state("noar_idle", 0, 0, 0);
        tick();
        expect_state("noar_reload", 3, 1, 0);
        bus.start = 1'b0;
        tick();
        expect_state("noar_2", 2, 1, 0);
        tick();
        expect_state("noar_1", 1, 1, 0);
        tick();
        expect_state("noar_done", 0, 0, 1);
        tick();
        expect_state("noar_end", 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
